noc_output_arbiter: RTL and testbench

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

---
 rtl/Noc_parameters.sv | 16 +
 rtl/noc_output_arbiter_if.sv | 39 +++
 rtl/noc_rr_picker.sv | 49 ++++
 rtl/noc_output_arbiter.sv | 144 ++++++++++++++
 tb/tb_noc_output_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/Noc_parameters.sv
// Shared types and constants for the NoC output arbiter and its round-robin picker.
package Noc_parameters;

    localparam int Noc_Port_Num = 5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width that stays legal (>= 1 bit) even for a single-port build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Bundle of the arbiter's request/transfer inputs and grant/status outputs.
// The master side is the input-port/switch logic; the slave side is the arbiter.
interface noc_output_arbiter_if
    import Noc_parameters::*;
#(
    parameter int N_PORTS = Noc_Port_Num
) ();

    localparam int IDX_W = idx_width(N_PORTS);

    logic [N_PORTS-1:0] req;
    logic               fire;
    logic               tail;
    logic [N_PORTS-1:0] grant;
    logic               locked;
    logic [IDX_W-1:0]   owner;
    logic               wdog_err;

    modport master (
        output req,
        output fire,
        output tail,
        input  grant,
        input  locked,
        input  owner,
        input  wdog_err
    );

    modport slave (
        input  req,
        input  fire,
        input  tail,
        output grant,
        output locked,
        output owner,
        output wdog_err
    );

endinterface

// File: rtl/noc_rr_picker.sv
// Combinational round-robin picker: searches req starting at ptr+1 (mod N_PORTS),
// so the port at ptr itself is considered last.
module noc_rr_picker
    import Noc_parameters::*;
#(
    parameter int N_PORTS = Noc_Port_Num,
    parameter int IDX_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] onehot,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0]      w_base;
    logic [IDX_W-1:0]   w_pos [N_PORTS];
    logic [N_PORTS-1:0] w_rot;

    assign w_base = {1'b0, ptr} + SW'(1);

    // w_pos[gi] is the port examined at search offset gi; w_rot is req in search order.
    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_rot
            logic [SW-1:0] w_sum;
            assign w_sum     = w_base + SW'(gi);
            assign w_pos[gi] = IDX_W'((w_sum >= SW'(N_PORTS)) ? (w_sum - SW'(N_PORTS)) : w_sum);
            assign w_rot[gi] = req[w_pos[gi]];
        end
    endgenerate

    // Descending scan so the smallest search offset wins.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                any   = 1'b1;
                index = w_pos[k];
            end
        end
    end

    assign onehot = any ? (N_PORTS'(1) << index) : '0;

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: round-robin grant, held until the tail flit transfers.
// Optional stall watchdog enabled by defining NOC_ARB_WATCHDOG_EN.
module noc_output_arbiter
    import Noc_parameters::*;
#(
    parameter  int N_PORTS     = Noc_Port_Num,
    parameter  int WDOG_CYCLES = 256,
    localparam int IDX_W       = idx_width(N_PORTS)
) (
    input  logic               noc_clk,
    input  logic               noc_rst_n,
    input  logic [N_PORTS-1:0] i_req,
    input  logic               i_fire,
    input  logic               i_tail,
    output logic [N_PORTS-1:0] o_grant,
    output logic               o_locked,
    output logic [IDX_W-1:0]   o_owner
`ifdef NOC_ARB_WATCHDOG_EN
    ,
    output logic               o_wdog_err
`endif
);

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    logic [N_PORTS-1:0] r_grant;
    logic [N_PORTS-1:0] w_grant_next;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_rr_ptr_next;

    logic [IDX_W-1:0]   w_ptr_sel;
    logic [N_PORTS-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_index;
    logic               w_pick_any;
    logic               w_release;
    logic               w_wdog_expire;

    // While locked the search starts after the owner, which makes a re-request
    // from the departing owner the lowest priority on release.
    assign w_ptr_sel = (r_state == LOCKED) ? r_owner : r_rr_ptr;

    noc_rr_picker #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (i_req),
        .ptr    (w_ptr_sel),
        .onehot (w_pick_onehot),
        .index  (w_pick_index),
        .any    (w_pick_any)
    );

    assign w_release = (r_state == LOCKED) && ((i_fire && i_tail) || w_wdog_expire);

`ifdef NOC_ARB_WATCHDOG_EN
    localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [CNT_W-1:0] r_wdog_cnt;
    logic [CNT_W-1:0] w_wdog_cnt_next;
    logic             r_wdog_err;

    assign w_wdog_expire = (r_state == LOCKED) && !i_fire &&
                           (r_wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

    always_comb begin
        w_wdog_cnt_next = r_wdog_cnt + CNT_W'(1);
        if ((r_state != LOCKED) || w_release || i_fire) begin
            w_wdog_cnt_next = '0;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_next;
            r_wdog_err <= w_wdog_expire;
        end
    end

    assign o_wdog_err = r_wdog_err;
`else
    logic w_unused_wdog_cfg;

    assign w_wdog_expire     = 1'b0;
    assign w_unused_wdog_cfg = (WDOG_CYCLES == 0);
`endif

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_owner_next  = r_owner;
        w_rr_ptr_next = r_rr_ptr;
        case (r_state)
            IDLE: begin
                w_grant_next = '0;
                if (w_pick_any) begin
                    w_state_next = LOCKED;
                    w_grant_next = w_pick_onehot;
                    w_owner_next = w_pick_index;
                end
            end
            LOCKED: begin
                // Hand off straight to the next requester so the output sees no bubble.
                if (w_release) begin
                    w_rr_ptr_next = r_owner;
                    if (w_pick_any) begin
                        w_grant_next = w_pick_onehot;
                        w_owner_next = w_pick_index;
                    end else begin
                        w_state_next = IDLE;
                        w_grant_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= IDX_W'(N_PORTS - 1);
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_owner  <= w_owner_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    assign o_grant  = r_grant;
    assign o_locked = (r_state == LOCKED);
    assign o_owner  = r_owner;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter: stimulus queues expected outputs,
// a monitor compares them after each rising edge.
module tb_noc_output_arbiter;

    logic clk;
    logic rst_n;

    noc_output_arbiter_if #(.N_PORTS(5)) bus ();

    noc_output_arbiter #(
        .N_PORTS     (5),
        .WDOG_CYCLES (8)
    ) dut (
        .noc_clk    (clk),
        .noc_rst_n  (rst_n),
        .i_req      (bus.req),
        .i_fire     (bus.fire),
        .i_tail     (bus.tail),
        .o_grant    (bus.grant),
        .o_locked   (bus.locked),
        .o_owner    (bus.owner)
`ifdef NOC_ARB_WATCHDOG_EN
        ,
        .o_wdog_err (bus.wdog_err)
`endif
    );

`ifndef NOC_ARB_WATCHDOG_EN
    assign bus.wdog_err = 1'b0;
`endif

    typedef struct {
        logic [4:0] grant;
        logic       locked;
        logic [2:0] owner;
        logic       wdog_err;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: the arbiter presents a registered result every cycle.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_val({mon_e.name, ".grant"}, 32'(bus.grant), 32'(mon_e.grant));
            check_val({mon_e.name, ".locked"}, 32'(bus.locked), 32'(mon_e.locked));
            if (mon_e.locked) begin
                check_val({mon_e.name, ".owner"}, 32'(bus.owner), 32'(mon_e.owner));
            end
            check_val({mon_e.name, ".wdog_err"}, 32'(bus.wdog_err), 32'(mon_e.wdog_err));
            $display("txn %-14s grant=%b locked=%b owner=%0d wdog_err=%b",
                     mon_e.name, bus.grant, bus.locked, bus.owner, bus.wdog_err);
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic [4:0] req, input logic fire, input logic tail,
                        input logic [4:0] g, input logic l, input logic [2:0] o,
                        input logic w, input string name);
        exp_t e;
        bus.req  = req;
        bus.fire = fire;
        bus.tail = tail;
        e.grant    = g;
        e.locked   = l;
        e.owner    = o;
        e.wdog_err = w;
        e.name     = name;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".grant"}, 32'(bus.grant), 32'd0);
        check_val({tag, ".locked"}, 32'(bus.locked), 32'd0);
        check_val({tag, ".owner"}, 32'(bus.owner), 32'd0);
        check_val({tag, ".wdog_err"}, 32'(bus.wdog_err), 32'd0);
        $display("txn %-14s grant=%b locked=%b owner=%0d", tag, bus.grant, bus.locked, bus.owner);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.fire = 1'b0;
        bus.tail = 1'b0;
        #2;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First grant from reset starts at port 0.
        step(5'b10101, 1'b0, 1'b0, 5'b00001, 1'b1, 3'd0, 1'b0, "grant_p0");
        for (int i = 0; i < 3; i++) begin
            step(5'b10101, 1'b1, 1'b0, 5'b00001, 1'b1, 3'd0, 1'b0, "body_hold");
        end
        step(5'b10100, 1'b1, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b0, "handoff_p2");
        step(5'b00100, 1'b1, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b0, "regrant_self");
        step(5'b00101, 1'b1, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b0, "owner_lowest");
        step(5'b01000, 1'b1, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0, "to_p3");

        // Request withdrawal and competing requests must not break the lock.
        step(5'b00000, 1'b0, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b0, "req_dropped");
        step(5'b00011, 1'b0, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b0, "no_preempt");
        step(5'b00000, 1'b1, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b0, "body_noreq");
        step(5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, "tail_to_idle");
        step(5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, "idle_ignore");
        step(5'b10001, 1'b0, 1'b0, 5'b10000, 1'b1, 3'd4, 1'b0, "rr_from_p3");
        step(5'b10001, 1'b1, 1'b0, 5'b10000, 1'b1, 3'd4, 1'b0, "p4_body");

        // Asynchronous reset in the middle of owner 4's packet.
        bus.fire = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        bus.req = 5'b11111;
        @(negedge clk);
        rst_n = 1'b1;
        step(5'b11111, 1'b0, 1'b0, 5'b00001, 1'b1, 3'd0, 1'b0, "post_reset_p0");
        step(5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, "single_flit");
        step(5'b00011, 1'b0, 1'b0, 5'b00010, 1'b1, 3'd1, 1'b0, "rr_from_p0");

`ifdef NOC_ARB_WATCHDOG_EN
        // Owner 1 stalls: seven tolerated cycles, the eighth forces a handoff to port 2.
        for (int i = 0; i < 7; i++) begin
            step(5'b00110, 1'b0, 1'b0, 5'b00010, 1'b1, 3'd1, 1'b0, "wdog_stall");
        end
        step(5'b00110, 1'b0, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b1, "wdog_expire");
        step(5'b00000, 1'b0, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b0, "wdog_pulse_end");
        step(5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, "wdog_tail");
`else
        // Without the watchdog a long stall keeps the lock.
        for (int i = 0; i < 12; i++) begin
            step(5'b00110, 1'b0, 1'b0, 5'b00010, 1'b1, 3'd1, 1'b0, "long_stall");
        end
        step(5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, "stall_tail");
`endif

        bus.req  = '0;
        bus.fire = 1'b0;
        bus.tail = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
